// File: rtl/nn_sequencer.sv
// Instruction sequencer for the NN accelerator: fetches repeat-counted instructions
// and drives registered per-cycle control for the MAC array, serializer and memories.
module nn_sequencer #(
  parameter int INST_WIDTH     = 32,
  parameter int INST_MEM_DEPTH = 8,
  parameter int NU_COUNT       = 8,
  parameter int XY_MEM_DEPTH   = 10,
  parameter int W_MEM_DEPTH    = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [INST_MEM_DEPTH-1:0] start_pc,
  output logic                      busy,
  output logic                      done,
  output logic [INST_MEM_DEPTH-1:0] inst_addr,
  input  logic [INST_WIDTH-1:0]     inst_data,
  output logic [NU_COUNT-1:0]       mac_reg_enable,
  output logic                      mac_acc_loopback,
  output logic                      mac_x_select,
  output logic                      mac_w_select,
  output logic                      serializer_update,
  output logic                      act_input_select,
  output logic                      xy_acc_loopback,
  output logic [XY_MEM_DEPTH-1:0]   xy_read_addr,
  output logic [XY_MEM_DEPTH-1:0]   xy_write_addr,
  output logic                      xy_write_enable,
  output logic [W_MEM_DEPTH-1:0]    w_read_addr,
  output logic [W_MEM_DEPTH-1:0]    w_write_addr,
  output logic                      w_write_enable
);

  localparam logic [3:0] OP_MATMUL     = 4'h1;
  localparam logic [3:0] OP_ACCMOV     = 4'h2;
  localparam logic [3:0] OP_LOADMAC    = 4'h3;
  localparam logic [3:0] OP_MATMULT    = 4'h4;
  localparam logic [3:0] OP_VECTTOMAT  = 4'h5;
  localparam logic [3:0] OP_WCONSTPROD = 4'h6;
  localparam logic [3:0] OP_WACC       = 4'h7;
  localparam logic [3:0] OP_HALT       = 4'hF;

  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_DONE} state_e;

  typedef struct packed {
    logic [NU_COUNT-1:0]     mac_reg_enable;
    logic                    mac_acc_loopback;
    logic                    mac_x_select;
    logic                    mac_w_select;
    logic                    serializer_update;
    logic                    act_input_select;
    logic                    xy_acc_loopback;
    logic [XY_MEM_DEPTH-1:0] xy_read_addr;
    logic [XY_MEM_DEPTH-1:0] xy_write_addr;
    logic                    xy_write_enable;
    logic [W_MEM_DEPTH-1:0]  w_read_addr;
    logic [W_MEM_DEPTH-1:0]  w_write_addr;
    logic                    w_write_enable;
  } ctl_t;

  state_e                    r_state, w_state_next;
  logic [INST_MEM_DEPTH-1:0] r_pc, w_pc_next;
  logic [3:0]                r_op, w_op_next;
  logic [11:0]               r_count, w_count_next;
  logic [11:0]               r_i, w_i_next;
  logic [15:0]               r_operand, w_operand_next;
  logic                      r_done;
  ctl_t                      r_ctl, w_ctl, w_exec;
  logic [16:0]               w_sum;
  logic [16:0]               w_mac_sel;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_op_next      = r_op;
    w_count_next   = r_count;
    w_operand_next = r_operand;
    w_i_next       = r_i;
    case (r_state)
      ST_IDLE: if (start) begin
        w_pc_next    = start_pc;
        w_state_next = ST_FETCH;
      end
      ST_FETCH:  w_state_next = ST_DECODE;
      ST_DECODE: begin
        w_op_next      = inst_data[INST_WIDTH-1 -: 4];
        w_count_next   = inst_data[INST_WIDTH-5 -: 12];
        w_operand_next = inst_data[15:0];
        w_i_next       = '0;
        w_state_next   = (inst_data[INST_WIDTH-1 -: 4] == OP_HALT) ? ST_DONE : ST_EXEC;
      end
      ST_EXEC: begin
        if (r_i == r_count) begin
          w_pc_next    = r_pc + INST_MEM_DEPTH'(1);
          w_state_next = ST_FETCH;
        end else begin
          w_i_next = r_i + 12'd1;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are computed from next-cycle values so the registered controls line up with EXEC.
  assign w_sum     = {1'b0, w_operand_next} + 17'(w_i_next);
  assign w_mac_sel = w_sum % 17'(NU_COUNT);

  always_comb begin
    w_exec = '0;
    case (w_op_next)
      OP_MATMUL: begin
        w_exec.mac_x_select      = 1'b1;
        w_exec.mac_w_select      = 1'b1;
        w_exec.serializer_update = 1'b1;
        w_exec.xy_read_addr      = XY_MEM_DEPTH'(w_sum);
        w_exec.w_read_addr       = W_MEM_DEPTH'(w_i_next);
        w_exec.mac_acc_loopback  = (w_i_next != '0);
      end
      OP_ACCMOV: begin
        w_exec.act_input_select = 1'b1;
        w_exec.xy_write_enable  = 1'b1;
        w_exec.xy_write_addr    = XY_MEM_DEPTH'(w_sum);
      end
      OP_LOADMAC: begin
        w_exec.mac_reg_enable = NU_COUNT'(1) << w_mac_sel;
        w_exec.w_read_addr    = W_MEM_DEPTH'(w_i_next);
      end
      OP_MATMULT: begin
        w_exec.mac_w_select    = 1'b1;
        w_exec.xy_write_enable = 1'b1;
        w_exec.xy_write_addr   = XY_MEM_DEPTH'(w_sum);
        w_exec.xy_acc_loopback = 1'b1;
      end
      OP_VECTTOMAT, OP_WCONSTPROD, OP_WACC: begin
        w_exec.xy_read_addr   = XY_MEM_DEPTH'(w_i_next);
        w_exec.w_write_enable = 1'b1;
        w_exec.w_write_addr   = W_MEM_DEPTH'(w_sum);
        if (w_op_next != OP_VECTTOMAT) begin
          w_exec.mac_x_select = 1'b1;
          w_exec.mac_w_select = 1'b1;
        end
        if (w_op_next == OP_WACC) begin
          w_exec.mac_acc_loopback = 1'b1;
          w_exec.xy_read_addr     = '0;
        end
      end
      default: w_exec = '0;
    endcase

    // Outside EXEC the strobes drop but addresses hold their last value.
    w_ctl                   = '0;
    w_ctl.xy_read_addr      = r_ctl.xy_read_addr;
    w_ctl.xy_write_addr     = r_ctl.xy_write_addr;
    w_ctl.w_read_addr       = r_ctl.w_read_addr;
    w_ctl.w_write_addr      = r_ctl.w_write_addr;
    if (w_state_next == ST_EXEC) w_ctl = w_exec;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_op      <= '0;
      r_count   <= '0;
      r_operand <= '0;
      r_i       <= '0;
      r_done    <= 1'b0;
      r_ctl     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_op      <= w_op_next;
      r_count   <= w_count_next;
      r_operand <= w_operand_next;
      r_i       <= w_i_next;
      r_done    <= (r_state == ST_DONE);
      r_ctl     <= w_ctl;
    end
  end

  assign busy              = (r_state != ST_IDLE);
  assign done              = r_done;
  assign inst_addr         = r_pc;
  assign mac_reg_enable    = r_ctl.mac_reg_enable;
  assign mac_acc_loopback  = r_ctl.mac_acc_loopback;
  assign mac_x_select      = r_ctl.mac_x_select;
  assign mac_w_select      = r_ctl.mac_w_select;
  assign serializer_update = r_ctl.serializer_update;
  assign act_input_select  = r_ctl.act_input_select;
  assign xy_acc_loopback   = r_ctl.xy_acc_loopback;
  assign xy_read_addr      = r_ctl.xy_read_addr;
  assign xy_write_addr     = r_ctl.xy_write_addr;
  assign xy_write_enable   = r_ctl.xy_write_enable;
  assign w_read_addr       = r_ctl.w_read_addr;
  assign w_write_addr      = r_ctl.w_write_addr;
  assign w_write_enable    = r_ctl.w_write_enable;

endmodule

// File: tb/tb_nn_sequencer.sv
// Self-checking bench for nn_sequencer: directed vector table, hand-written corner
// sequences and random programs compared cycle-by-cycle against a program-level model.
module tb_nn_sequencer;

  typedef struct packed {
    logic [7:0] mre;
    logic       accl, xs, ws, ser, act, xyacc;
    logic [9:0] xyra, xywa;
    logic       xywe;
    logic [9:0] wra, wwa;
    logic       wwe;
  } ctl_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] pc;
    ctl_t       c;
  } obs_t;

  typedef struct {
    logic [3:0]  op;
    logic [11:0] cnt;
    logic [15:0] opnd;
    int          i;
    ctl_t        c;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  start_pc;
  logic        busy, done;
  logic [7:0]  inst_addr;
  logic [31:0] inst_data;
  logic [7:0]  mac_reg_enable;
  logic        mac_acc_loopback, mac_x_select, mac_w_select, serializer_update;
  logic        act_input_select, xy_acc_loopback, xy_write_enable, w_write_enable;
  logic [9:0]  xy_read_addr, xy_write_addr, w_read_addr, w_write_addr;

  logic [31:0] mem [256];
  int          n_cmp = 0;
  int          n_fail = 0;
  obs_t        exp_q [$];
  logic [9:0]  h_xyra, h_xywa, h_wra, h_wwa;
  logic [7:0]  h_pc;

  always #5 clk = ~clk;

  always_ff @(posedge clk) inst_data <= mem[inst_addr];

  nn_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .busy(busy), .done(done), .inst_addr(inst_addr), .inst_data(inst_data),
    .mac_reg_enable(mac_reg_enable), .mac_acc_loopback(mac_acc_loopback),
    .mac_x_select(mac_x_select), .mac_w_select(mac_w_select),
    .serializer_update(serializer_update), .act_input_select(act_input_select),
    .xy_acc_loopback(xy_acc_loopback), .xy_read_addr(xy_read_addr),
    .xy_write_addr(xy_write_addr), .xy_write_enable(xy_write_enable),
    .w_read_addr(w_read_addr), .w_write_addr(w_write_addr), .w_write_enable(w_write_enable)
  );

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic obs_t get_obs();
    obs_t o;
    o.busy = busy;                 o.done = done;                o.pc = inst_addr;
    o.c.mre = mac_reg_enable;      o.c.accl = mac_acc_loopback;  o.c.xs = mac_x_select;
    o.c.ws = mac_w_select;         o.c.ser = serializer_update;  o.c.act = act_input_select;
    o.c.xyacc = xy_acc_loopback;   o.c.xyra = xy_read_addr;      o.c.xywa = xy_write_addr;
    o.c.xywe = xy_write_enable;    o.c.wra = w_read_addr;        o.c.wwa = w_write_addr;
    o.c.wwe = w_write_enable;
    return o;
  endfunction

  function automatic ctl_t mk(logic [7:0] mre, logic accl, logic xs, logic ws, logic ser,
                              logic act, logic xyacc, logic [9:0] xyra, logic [9:0] xywa,
                              logic xywe, logic [9:0] wra, logic [9:0] wwa, logic wwe);
    ctl_t c;
    c = '{mre, accl, xs, ws, ser, act, xyacc, xyra, xywa, xywe, wra, wwa, wwe};
    return c;
  endfunction

  // Non-EXEC cycle: strobes low, addresses keep whatever the last EXEC cycle drove.
  function automatic obs_t hold_obs(logic b, logic [7:0] pc);
    obs_t o = '0;
    o.busy = b; o.pc = pc;
    o.c.xyra = h_xyra; o.c.xywa = h_xywa; o.c.wra = h_wra; o.c.wwa = h_wwa;
    return o;
  endfunction

  function automatic obs_t exec_obs(logic [3:0] op, logic [15:0] opnd, int i, logic [7:0] pc);
    obs_t o = '0;
    int a = int'(opnd) + i;
    logic [9:0] a10 = a[9:0];
    logic [9:0] i10 = i[9:0];
    o.busy = 1'b1; o.pc = pc;
    case (op)
      4'h1: begin o.c.xs = 1; o.c.ws = 1; o.c.ser = 1; o.c.xyra = a10; o.c.wra = i10;
                  o.c.accl = (i != 0); end
      4'h2: begin o.c.act = 1; o.c.xywe = 1; o.c.xywa = a10; end
      4'h3: begin o.c.mre = 8'd1 << (a % 8); o.c.wra = i10; end
      4'h4: begin o.c.ws = 1; o.c.xywe = 1; o.c.xywa = a10; o.c.xyacc = 1; end
      4'h5, 4'h6, 4'h7: begin
        o.c.xyra = i10; o.c.wwe = 1; o.c.wwa = a10;
        if (op != 4'h5) begin o.c.xs = 1; o.c.ws = 1; end
        if (op == 4'h7) begin o.c.accl = 1; o.c.xyra = '0; end
      end
      default: ;
    endcase
    h_xyra = o.c.xyra; h_xywa = o.c.xywa; h_wra = o.c.wra; h_wwa = o.c.wwa;
    return o;
  endfunction

  // Expected trace from the FETCH of the first instruction to one idle cycle after done.
  task automatic model_program(input logic [7:0] spc);
    logic [7:0] pc = spc;
    exp_q.delete();
    while (exp_q.size() < 30000) begin
      logic [31:0] inst = mem[pc];
      exp_q.push_back(hold_obs(1'b1, pc));
      exp_q.push_back(hold_obs(1'b1, pc));
      if (inst[31:28] == 4'hF) begin
        obs_t d = hold_obs(1'b0, pc);
        d.done = 1'b1;
        exp_q.push_back(hold_obs(1'b1, pc));
        exp_q.push_back(d);
        exp_q.push_back(hold_obs(1'b0, pc));
        break;
      end
      for (int i = 0; i <= int'(inst[27:16]); i++)
        exp_q.push_back(exec_obs(inst[31:28], inst[15:0], i, pc));
      pc = pc + 8'd1;
    end
    h_pc = pc;
  endtask

  task automatic run_program(input logic [7:0] spc, input string tag, input int poke_at);
    model_program(spc);
    @(negedge clk); start = 1'b1; start_pc = spc;
    @(negedge clk); start = 1'b0; start_pc = ~spc;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == poke_at) begin start = 1'b1; start_pc = spc + 8'd7; end
      check($sformatf("%s cyc%0d", tag, k), 128'(get_obs()), 128'(exp_q[k]));
      @(negedge clk); start = 1'b0;
    end
  endtask

  task automatic clear_model();
    h_xyra = '0; h_xywa = '0; h_wra = '0; h_wwa = '0; h_pc = '0;
  endtask

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{4'h1, 12'd3, 16'h0010, 0, mk(8'h00,0,1,1,1,0,0,10'h010,10'h000,0,10'd0,10'h000,0)};
    vecs[1]  = '{4'h1, 12'd3, 16'h0010, 3, mk(8'h00,1,1,1,1,0,0,10'h013,10'h000,0,10'd3,10'h000,0)};
    vecs[2]  = '{4'h2, 12'd3, 16'h03FE, 2, mk(8'h00,0,0,0,0,1,0,10'h000,10'h000,1,10'd0,10'h000,0)};
    vecs[3]  = '{4'h3, 12'd9, 16'h0006, 0, mk(8'h40,0,0,0,0,0,0,10'h000,10'h000,0,10'd0,10'h000,0)};
    vecs[4]  = '{4'h3, 12'd9, 16'h0006, 2, mk(8'h01,0,0,0,0,0,0,10'h000,10'h000,0,10'd2,10'h000,0)};
    vecs[5]  = '{4'h3, 12'd9, 16'h0006, 9, mk(8'h80,0,0,0,0,0,0,10'h000,10'h000,0,10'd9,10'h000,0)};
    vecs[6]  = '{4'h4, 12'd1, 16'h0205, 1, mk(8'h00,0,0,1,0,0,1,10'h000,10'h206,1,10'd0,10'h000,0)};
    vecs[7]  = '{4'h5, 12'd4, 16'h03FF, 1, mk(8'h00,0,0,0,0,0,0,10'h001,10'h000,0,10'd0,10'h000,1)};
    vecs[8]  = '{4'h6, 12'd2, 16'h0100, 2, mk(8'h00,0,1,1,0,0,0,10'h002,10'h000,0,10'd0,10'h102,1)};
    vecs[9]  = '{4'h7, 12'd3, 16'h0007, 3, mk(8'h00,1,1,1,0,0,0,10'h000,10'h000,0,10'd0,10'h00A,1)};
    vecs[10] = '{4'h0, 12'd2, 16'hFFFF, 1, mk(8'h00,0,0,0,0,0,0,10'h000,10'h000,0,10'd0,10'h000,0)};
    vecs[11] = '{4'hB, 12'd0, 16'h0055, 0, mk(8'h00,0,0,0,0,0,0,10'h000,10'h000,0,10'd0,10'h000,0)};
    vecs[12] = '{4'h1, 12'd1, 16'hFFFF, 1, mk(8'h00,1,1,1,1,0,0,10'h000,10'h000,0,10'd1,10'h000,0)};

    for (int k = 0; k < 256; k++) mem[k] = 32'hF000_0000;
    clear_model();
    reset = 1'b1; start = 1'b0; start_pc = '0;
    repeat (3) @(negedge clk);
    check("reset state", 128'(get_obs()), 128'(obs_t'('0)));
    reset = 1'b0;
    @(negedge clk);
    check("idle after reset", 128'(get_obs()), 128'(obs_t'('0)));

    // Directed vectors: one instruction at 0x20, check the EXEC cycle with iteration i.
    for (int v = 0; v < 13; v++) begin
      obs_t want = '0;
      int   n = 0;
      mem[8'h20] = {vecs[v].op, vecs[v].cnt, vecs[v].opnd};
      mem[8'h21] = 32'hF000_0000;
      want.busy = 1'b1; want.pc = 8'h20; want.c = vecs[v].c;
      @(negedge clk); start = 1'b1; start_pc = 8'h20;
      @(negedge clk); start = 1'b0;
      repeat (2 + vecs[v].i) @(negedge clk);
      check($sformatf("vec%0d", v), 128'(get_obs()), 128'(want));
      while (busy && n < 100) begin @(negedge clk); n++; end
      check($sformatf("vec%0d settle busy", v), 128'(busy), 128'(1'b0));
      @(negedge clk);
      model_program(8'h20);
    end

    // Reset in the middle of a MATMUL.
    mem[8'h30] = {4'h1, 12'd5, 16'h0123};
    mem[8'h31] = 32'hF000_0000;
    @(negedge clk); start = 1'b1; start_pc = 8'h30;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset xy_read_addr", 128'(xy_read_addr), 128'(10'h125));
    reset = 1'b1;
    @(negedge clk);
    clear_model();
    check("reset mid-exec", 128'(get_obs()), 128'(obs_t'('0)));
    reset = 1'b0;
    @(negedge clk);
    check("idle after mid-exec reset", 128'(get_obs()), 128'(obs_t'('0)));

    // start coincident with reset must be ignored.
    reset = 1'b1; start = 1'b1; start_pc = 8'h40;
    @(negedge clk); reset = 1'b0; start = 1'b0;
    check("start with reset", 128'(get_obs()), 128'(obs_t'('0)));
    @(negedge clk);
    check("still idle", 128'(get_obs()), 128'(obs_t'('0)));

    // start pulsed during EXEC is ignored; a later start launches normally.
    mem[8'h40] = {4'h1, 12'd4, 16'h03FE};
    mem[8'h41] = 32'hF000_0000;
    run_program(8'h40, "start-in-exec", 4);

    mem[8'h03] = {4'h1, 12'd3, 16'h0010};
    mem[8'h04] = 32'hF000_0000;
    run_program(8'h03, "matmul pc3", -1);

    mem[8'h50] = {4'hA, 12'd2, 16'h1234};
    mem[8'h51] = {4'h7, 12'd0, 16'h0012};
    mem[8'h52] = 32'hF000_0000;
    run_program(8'h50, "op A + wacc", -1);

    mem[8'h60] = {4'h3, 12'd9, 16'h0006};
    mem[8'h61] = {4'h2, 12'd3, 16'h03FE};
    mem[8'h62] = 32'hF000_0000;
    run_program(8'h60, "loadmac+accmov", -1);

    // Program wrapping past the top of instruction memory.
    mem[8'hFF] = {4'h6, 12'd1, 16'h0200};
    mem[8'h00] = {4'h4, 12'd0, 16'h0001};
    mem[8'h01] = 32'hF000_0000;
    run_program(8'hFF, "pc wrap", -1);

    mem[8'h90] = {4'h3, 12'hFFF, 16'hFFFE};
    mem[8'h91] = 32'hF000_0000;
    run_program(8'h90, "count FFF", -1);

    for (int r = 0; r < 8; r++) begin
      int         n = $urandom_range(1, 5);
      logic [7:0] spc = 8'($urandom_range(0, 255));
      for (int j = 0; j < n; j++)
        mem[8'(spc + 8'(j))] = {4'($urandom_range(0, 14)), 12'($urandom_range(0, 6)), 16'($urandom)};
      mem[8'(spc + 8'(n))] = 32'hF000_0000;
      run_program(spc, $sformatf("rand%0d", r), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
